regfile_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single shared port of the 8×16 register file. Each requester presents a read or write command. The block grants one command at a time and drives the register file's mutually exclusive RdEn/WrEn port. Read data returns to the requester that issued the read. It sits between the register file and its two client blocks (A, B) and is the only driver of the register-file port.

---
 rtl/regfile_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sequencer that lets two clients (A, B) share the
// single RdEn/WrEn port of the 8x16 register file and routes read data back to
// the client that issued the read.
module regfile_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned WIDTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic              WrA,
  input  logic              WrB,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [WIDTH-1:0]  WrDataA,
  input  logic [WIDTH-1:0]  WrDataB,
  output logic              GntA,
  output logic              GntB,
  output logic              RdValidA,
  output logic              RdValidB,
  output logic [WIDTH-1:0]  RdDataA,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              RF_WrEn,
  output logic              RF_RdEn,
  output logic [ADDR_W-1:0] RF_Address,
  output logic [WIDTH-1:0]  RF_WrData,
  input  logic [WIDTH-1:0]  RF_RdData
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;

  state_t state;
  state_t state_nxt;
  logic   last_b;   // 1: B was served last
  logic   id_b;     // owner of the operation in flight (1: B)
  logic   win_a;
  logic   win_b;
  logic   win_wr;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last
  always_comb begin
    win_a  = ReqA && (!ReqB || last_b);
    win_b  = ReqB && (!ReqA || !last_b);
    win_wr = win_a ? WrA : WrB;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_a || win_b) state_nxt = win_wr ? WR : RD;
      WR:      state_nxt = IDLE;
      RD:      state_nxt = RD_CAP;
      RD_CAP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are only issued from IDLE
  always_comb begin
    GntA = (state == IDLE) && win_a;
    GntB = (state == IDLE) && win_b;
  end

  // State register, round-robin pointer and owner of the in-flight operation
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      last_b <= 1'b1;
      id_b   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (GntA || GntB) begin
        last_b <= GntB;
        id_b   <= GntB;
      end
    end
  end

  // Register-file port: enables follow the next state, address/data change only on a grant
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
    end else begin
      RF_WrEn <= (state_nxt == WR);
      RF_RdEn <= (state_nxt == RD);
      if (GntA) begin
        RF_Address <= AddrA;
        RF_WrData  <= WrDataA;
      end else if (GntB) begin
        RF_Address <= AddrB;
        RF_WrData  <= WrDataB;
      end
    end
  end

  // Read return: capture RF data in RD_CAP into the owner's register and pulse its valid
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdValidA <= 1'b0;
      RdValidB <= 1'b0;
      RdDataA  <= '0;
      RdDataB  <= '0;
    end else begin
      RdValidA <= (state == RD_CAP) && !id_b;
      RdValidB <= (state == RD_CAP) && id_b;
      if (state == RD_CAP) begin
        if (id_b) RdDataB <= RF_RdData;
        else      RdDataA <= RF_RdData;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed cycle table, reset-during-read sequence and a
// randomized run against a transaction-level model of the register file.
module tb_regfile_arbiter;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;
  localparam int          NV = 23;
  localparam int          NOPS = 200;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ReqA = 1'b0, ReqB = 1'b0, WrA = 1'b0, WrB = 1'b0;
  logic [AW-1:0] AddrA = '0, AddrB = '0;
  logic [DW-1:0] WrDataA = '0, WrDataB = '0;
  logic          GntA, GntB, RdValidA, RdValidB, RF_WrEn, RF_RdEn;
  logic [DW-1:0] RdDataA, RdDataB, RF_WrData;
  logic [AW-1:0] RF_Address;
  logic [DW-1:0] RF_RdData = '0;
  logic [DW-1:0] rf [8] = '{default: '0};

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  regfile_arbiter #(.ADDR_W(AW), .WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .ReqA(ReqA), .ReqB(ReqB), .WrA(WrA), .WrB(WrB),
    .AddrA(AddrA), .AddrB(AddrB), .WrDataA(WrDataA), .WrDataB(WrDataB),
    .GntA(GntA), .GntB(GntB), .RdValidA(RdValidA), .RdValidB(RdValidB),
    .RdDataA(RdDataA), .RdDataB(RdDataB),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData)
  );

  // Register file: write at the edge ending the WrEn cycle, read data valid the cycle after RdEn
  always @(posedge CLK) begin
    if (RF_WrEn) rf[RF_Address] <= RF_WrData;
    if (RF_RdEn) RF_RdData <= rf[RF_Address];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int ra, rb, wa, wb, aa, ab, da, db;
    int ga, gb, we, re, ad, wd, va, vb, xa, xb;
  } vec_t;
  vec_t tbl [NV];

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } rd_t;
  rd_t qa[$];
  rd_t qb[$];
  logic [DW-1:0] sb [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //         ra rb wa wb aa ab da       db        ga gb we re ad wd       va vb xa       xb
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 0, 0, 0,       0, 0, 0,       0};
    tbl[1]  = '{1, 1, 1, 1, 1, 2, 'hAAAA, 'hBBBB,   1, 0, 0, 0, 0, 0,       0, 0, 0,       0};
    tbl[2]  = '{1, 1, 1, 1, 1, 2, 'hAAAA, 'hBBBB,   0, 0, 1, 0, 1, 'hAAAA, 0, 0, 0,       0};
    tbl[3]  = '{1, 1, 1, 1, 1, 2, 'hAAAA, 'hBBBB,   0, 1, 0, 0, 1, 'hAAAA, 0, 0, 0,       0};
    tbl[4]  = '{1, 1, 1, 1, 1, 2, 'hAAAA, 'hBBBB,   0, 0, 1, 0, 2, 'hBBBB, 0, 0, 0,       0};
    tbl[5]  = '{1, 1, 1, 1, 1, 2, 'hAAAA, 'hBBBB,   1, 0, 0, 0, 2, 'hBBBB, 0, 0, 0,       0};
    tbl[6]  = '{1, 1, 1, 1, 1, 2, 'hAAAA, 'hBBBB,   0, 0, 1, 0, 1, 'hAAAA, 0, 0, 0,       0};
    tbl[7]  = '{1, 1, 1, 1, 1, 2, 'hAAAA, 'hBBBB,   0, 1, 0, 0, 1, 'hAAAA, 0, 0, 0,       0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 1, 0, 2, 'hBBBB, 0, 0, 0,       0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 0, 2, 'hBBBB, 0, 0, 0,       0};
    tbl[10] = '{1, 0, 1, 0, 5, 0, 'h1234, 0,        1, 0, 0, 0, 2, 'hBBBB, 0, 0, 0,       0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 1, 0, 5, 'h1234, 0, 0, 0,       0};
    tbl[12] = '{1, 0, 0, 0, 5, 0, 'h5555, 0,        1, 0, 0, 0, 5, 'h1234, 0, 0, 0,       0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 1, 5, 'h5555, 0, 0, 0,       0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 0, 5, 'h5555, 0, 0, 0,       0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 0, 5, 'h5555, 1, 0, 'h1234, 0};
    tbl[16] = '{1, 0, 1, 0, 7, 0, 'h00FF, 0,        1, 0, 0, 0, 5, 'h5555, 0, 0, 'h1234, 0};
    tbl[17] = '{0, 1, 0, 0, 0, 7, 0,       0,        0, 0, 1, 0, 7, 'h00FF, 0, 0, 'h1234, 0};
    tbl[18] = '{0, 1, 0, 0, 0, 7, 0,       0,        0, 1, 0, 0, 7, 'h00FF, 0, 0, 'h1234, 0};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 1, 7, 0,       0, 0, 'h1234, 0};
    tbl[20] = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 0, 7, 0,       0, 0, 'h1234, 0};
    tbl[21] = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 0, 7, 0,       0, 1, 'h1234, 'h00FF};
    tbl[22] = '{0, 0, 0, 0, 0, 0, 0,       0,        0, 0, 0, 0, 7, 0,       0, 0, 'h1234, 'h00FF};

    // Reset held for 3 cycles: every output low
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("rst%0d.outs", i),
          64'({GntA, GntB, RdValidA, RdValidB, RF_WrEn, RF_RdEn, RF_Address,
               RF_WrData, RdDataA, RdDataB}), 64'd0);
    end
    @(posedge CLK); #1; RST = 1'b1;

    // Directed cycle table
    for (int i = 0; i < NV; i++) begin
      @(posedge CLK); #1;
      ReqA = 1'(tbl[i].ra);  ReqB = 1'(tbl[i].rb);
      WrA  = 1'(tbl[i].wa);  WrB  = 1'(tbl[i].wb);
      AddrA = AW'(tbl[i].aa); AddrB = AW'(tbl[i].ab);
      WrDataA = DW'(tbl[i].da); WrDataB = DW'(tbl[i].db);
      @(negedge CLK);
      chk($sformatf("v%0d.GntA", i),       64'(GntA),       64'(tbl[i].ga));
      chk($sformatf("v%0d.GntB", i),       64'(GntB),       64'(tbl[i].gb));
      chk($sformatf("v%0d.RF_WrEn", i),    64'(RF_WrEn),    64'(tbl[i].we));
      chk($sformatf("v%0d.RF_RdEn", i),    64'(RF_RdEn),    64'(tbl[i].re));
      chk($sformatf("v%0d.RF_Address", i), 64'(RF_Address), 64'(tbl[i].ad));
      chk($sformatf("v%0d.RF_WrData", i),  64'(RF_WrData),  64'(tbl[i].wd));
      chk($sformatf("v%0d.RdValidA", i),   64'(RdValidA),   64'(tbl[i].va));
      chk($sformatf("v%0d.RdValidB", i),   64'(RdValidB),   64'(tbl[i].vb));
      chk($sformatf("v%0d.RdDataA", i),    64'(RdDataA),    64'(tbl[i].xa));
      chk($sformatf("v%0d.RdDataB", i),    64'(RdDataB),    64'(tbl[i].xb));
    end

    // Reset during RD_CAP of a B read
    @(posedge CLK); #1; ReqB = 1'b1; WrB = 1'b0; AddrB = 3'd7;
    @(negedge CLK); chk("mr.GntB", 64'(GntB), 64'd1);
    @(posedge CLK); #1; ReqB = 1'b0;
    @(negedge CLK); chk("mr.RF_RdEn", 64'(RF_RdEn), 64'd1);
    @(posedge CLK); #3; RST = 1'b0;
    @(negedge CLK);
    chk("mr.RdDataB", 64'(RdDataB), 64'd0);
    chk("mr.RdDataA", 64'(RdDataA), 64'd0);
    chk("mr.RF_Address", 64'(RF_Address), 64'd0);
    chk("mr.RF_WrData", 64'(RF_WrData), 64'd0);
    @(posedge CLK); #1; RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("mr%0d.RdValidB", i), 64'(RdValidB), 64'd0);
      chk($sformatf("mr%0d.Gnt", i), 64'({GntA, GntB}), 64'd0);
      if (i < 2) begin
        @(posedge CLK); #1;
      end
    end
    @(posedge CLK); #1;
    ReqA = 1'b1; WrA = 1'b0; AddrA = 3'd1;
    ReqB = 1'b1; WrB = 1'b0; AddrB = 3'd2;
    @(negedge CLK); chk("pr.GntA", 64'(GntA), 64'd1); chk("pr.GntB", 64'(GntB), 64'd0);
    @(posedge CLK); #1; ReqA = 1'b0;
    @(negedge CLK); chk("pr.rd.GntB", 64'(GntB), 64'd0);
    @(posedge CLK); #1;
    @(negedge CLK); chk("pr.cap.GntB", 64'(GntB), 64'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pr.RdValidA", 64'(RdValidA), 64'd1);
    chk("pr.RdDataA", 64'(RdDataA), 64'hAAAA);
    chk("pr.GntB2", 64'(GntB), 64'd1);
    @(posedge CLK); #1; ReqB = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pr.RdValidB", 64'(RdValidB), 64'd1);
    chk("pr.RdDataB", 64'(RdDataB), 64'hBBBB);
    chk("pr.RdDataA.hold", 64'(RdDataA), 64'hAAAA);

    // Randomized traffic against a transaction-level model
    begin
      bit pa = 0, pb = 0, last_b = 1, done = 0;
      int busy = 0, issued = 0, win = 0;
      bit eva, evb;
      sb = '{default: '0};
      sb[1] = 16'hAAAA; sb[2] = 16'hBBBB; sb[5] = 16'h1234; sb[7] = 16'h00FF;
      for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
        @(posedge CLK); #1;
        if (!pa && issued < NOPS && $urandom_range(0, 3) != 0) begin
          pa = 1; issued++;
          WrA = 1'($urandom_range(0, 1)); AddrA = AW'($urandom_range(0, 7)); WrDataA = DW'($urandom);
        end
        if (!pb && issued < NOPS && $urandom_range(0, 3) != 0) begin
          pb = 1; issued++;
          WrB = 1'($urandom_range(0, 1)); AddrB = AW'($urandom_range(0, 7)); WrDataB = DW'($urandom);
        end
        ReqA = pa; ReqB = pb;
        @(negedge CLK);
        // winner: 0 none, 1 A, 2 B
        win = 0;
        if (busy == 0) begin
          if (pa && pb) win = last_b ? 1 : 2;
          else if (pa)  win = 1;
          else if (pb)  win = 2;
        end
        chk("rnd.GntA", 64'(GntA), 64'(win == 1));
        chk("rnd.GntB", 64'(GntB), 64'(win == 2));
        chk("rnd.excl", 64'(RF_WrEn && RF_RdEn), 64'd0);
        eva = (qa.size() > 0) && (qa[0].cyc == cyc);
        evb = (qb.size() > 0) && (qb[0].cyc == cyc);
        chk("rnd.RdValidA", 64'(RdValidA), 64'(eva));
        chk("rnd.RdValidB", 64'(RdValidB), 64'(evb));
        if (eva) begin chk("rnd.RdDataA", 64'(RdDataA), 64'(qa[0].d)); void'(qa.pop_front()); end
        if (evb) begin chk("rnd.RdDataB", 64'(RdDataB), 64'(qb[0].d)); void'(qb.pop_front()); end
        if (busy > 0) busy--;
        else if (win == 1) begin
          if (WrA) begin sb[AddrA] = WrDataA; busy = 1; end
          else begin qa.push_back(rd_t'{cyc + 3, sb[AddrA]}); busy = 2; end
          pa = 0; last_b = 0;
        end else if (win == 2) begin
          if (WrB) begin sb[AddrB] = WrDataB; busy = 1; end
          else begin qb.push_back(rd_t'{cyc + 3, sb[AddrB]}); busy = 2; end
          pb = 0; last_b = 1;
        end
        if (issued == NOPS && !pa && !pb && busy == 0 && qa.size() == 0 && qb.size() == 0)
          done = 1;
      end
      chk("rnd.drained", 64'(done), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
